// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm
//   Multi-cycle sequencer for the CPU datapath (FETCH/DECODE/EXECUTE/MEM/WB).
//   Drives the imem/dmem req-ack handshakes, the IR latch, the register-file
//   write strobe and the PC update strobe/select.
//
// Parameters
//   ACK_TIMEOUT  max wait cycles for imem_ack/dmem_ack, 0 = wait forever
//   CNT_WIDTH    width of the wait counter, must hold ACK_TIMEOUT
//
// Ports
//   clk, rst             clock (rising edge), synchronous active-high reset
//   opcode, funct3       fields of the latched instruction (funct3 unused)
//   branch_taken         comparator result for the current B-type instruction
//   imem_req/imem_ack    instruction fetch handshake
//   dmem_req/dmem_we     data access request, 1 = store / 0 = load
//   dmem_ack             data access done
//   ir_we, rf_we, pc_we  IR latch, register-file write and PC update strobes
//   pc_sel               0 = PC+4, 1 = PC+imm, 2 = rs1+imm
//   state                FSM state (debug)
//   fault                0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout
//
// Optional feature (macro CTRL_PERF_CNT_EN)
//   Adds retired_cnt[31:0] (+1 per pc_we) and cycle_cnt[31:0] (+1 per cycle
//   outside TRAP). Both wrap and clear on rst.

module cpu_control_fsm #(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        branch_taken,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        ir_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [2:0]  state,
  output logic [1:0]  fault
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] cycle_cnt
`endif
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam bit                   TIMEOUT_EN = (ACK_TIMEOUT != 0);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C  = CNT_WIDTH'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    F_NONE    = 2'd0,
    F_ILLEGAL = 2'd1,
    F_IMEM    = 2'd2,
    F_DMEM    = 2'd3
  } fault_e;

  state_e               state_q, state_d;
  fault_e               fault_q, fault_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic is_load, is_store, is_branch, is_jal, is_jalr, legal;

  logic unused_funct3;
  assign unused_funct3 = ^funct3;

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_S);
  assign is_branch = (opcode == OP_B);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);

  always_comb begin
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_S, OP_B,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    fault_d  = fault_q;
    // The counter only has meaning while waiting in FETCH/MEM; defaulting it
    // to zero everywhere else clears it on every entry into those states.
    cnt_d    = '0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'd0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_C)) begin
          state_d = S_TRAP;
          fault_d = F_IMEM;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      S_DECODE: begin
        if (legal) begin
          state_d = S_EXECUTE;
        end else begin
          state_d = S_TRAP;
          fault_d = F_ILLEGAL;
        end
      end

      S_EXECUTE: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          pc_we   = 1'b1;
          pc_sel  = branch_taken ? 2'd1 : 2'd0;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) begin
          if (is_store) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_C)) begin
          state_d = S_TRAP;
          fault_d = F_DMEM;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        state_d = S_FETCH;
      end

      S_TRAP: ;

      default: state_d = S_FETCH;
    endcase

    // Strobes and requests are suppressed for the whole reset cycle, whatever
    // state the register still holds.
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ir_we    = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      fault_q <= F_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;
  assign fault = fault_q;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_q, cycle_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      cycle_q   <= '0;
    end else begin
      if (pc_we) retired_q <= retired_q + 32'd1;
      if (state_q != S_TRAP) cycle_q <= cycle_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign cycle_cnt   = cycle_q;
`endif

endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm
//   Scoreboard bench for cpu_control_fsm (ACK_TIMEOUT = 4). Each driven cycle
//   pushes the expected output vector; a negedge monitor pops and compares.
//   Vector = {state, fault, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel}.
//   With CTRL_PERF_CNT_EN defined the performance counters are also checked.

module tb_cpu_control_fsm;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        branch_taken;
  logic        imem_req, imem_ack;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        ir_we, rf_we, pc_we;
  logic [1:0]  pc_sel;
  logic [2:0]  state;
  logic [1:0]  fault;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_cnt, cycle_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [12:0] exp_q[$];
  string       tag_q[$];
  logic [12:0] obs_vec;

  cpu_control_fsm #(
    .ACK_TIMEOUT (4),
    .CNT_WIDTH   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct3       (funct3),
    .branch_taken (branch_taken),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ack     (dmem_ack),
    .ir_we        (ir_we),
    .rf_we        (rf_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .state        (state),
    .fault        (fault)
`ifdef CTRL_PERF_CNT_EN
    ,
    .retired_cnt  (retired_cnt),
    .cycle_cnt    (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign obs_vec = {state, fault, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] ev(input logic [2:0] st, input logic [1:0] flt,
                                     input logic ireq, input logic irwe,
                                     input logic dreq, input logic dwe,
                                     input logic rfwe, input logic pcwe,
                                     input logic [1:0] sel);
    return {st, flt, ireq, irwe, dreq, dwe, rfwe, pcwe, sel};
  endfunction

  task automatic push(input string t, input logic [12:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [12:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, 32'(obs_vec), 32'(e));
    end
  end

  // Reset cycle: registers still show st/flt, every strobe and request is 0.
  task automatic do_reset(input logic [2:0] st, input logic [1:0] flt, input string nm);
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    push(nm, ev(st, flt, 0, 0, 0, 0, 0, 0, 2'd0));
    step();
    rst = 1'b0;
  endtask

  // Full legal instruction; stray=1 raises both acks while no request is up.
  task automatic run_instr(input logic [6:0] op, input logic taken, input int unsigned iw,
                           input int unsigned dw, input logic stray, input string nm);
    logic is_mem, is_st;
    logic [1:0] wb_sel;
    is_mem = (op == OP_LOAD) || (op == OP_S);
    is_st  = (op == OP_S);
    wb_sel = (op == OP_JAL) ? 2'd1 : ((op == OP_JALR) ? 2'd2 : 2'd0);
    opcode = op; branch_taken = taken; funct3 = 3'($urandom_range(0, 7));
    for (int unsigned i = 0; i < iw; i++) begin
      imem_ack = 1'b0; dmem_ack = stray;
      push({nm, "_fwait"}, ev(3'd0, 2'd0, 1, 0, 0, 0, 0, 0, 2'd0));
      step();
    end
    imem_ack = 1'b1; dmem_ack = 1'b0;
    push({nm, "_fetch"}, ev(3'd0, 2'd0, 1, 1, 0, 0, 0, 0, 2'd0));
    step();
    imem_ack = stray; dmem_ack = stray;
    push({nm, "_decode"}, ev(3'd1, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0));
    step();
    if (op == OP_B)
      push({nm, "_exec"}, ev(3'd2, 2'd0, 0, 0, 0, 0, 0, 1, {1'b0, taken}));
    else
      push({nm, "_exec"}, ev(3'd2, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0));
    step();
    imem_ack = 1'b0; dmem_ack = 1'b0;
    if (op == OP_B) return;
    if (is_mem) begin
      for (int unsigned i = 0; i < dw; i++) begin
        imem_ack = stray; dmem_ack = 1'b0;
        push({nm, "_mwait"}, ev(3'd3, 2'd0, 0, 0, 1, is_st, 0, 0, 2'd0));
        step();
      end
      imem_ack = 1'b0; dmem_ack = 1'b1;
      push({nm, "_mack"}, ev(3'd3, 2'd0, 0, 0, 1, is_st, 0, is_st, 2'd0));
      step();
      dmem_ack = 1'b0;
      if (is_st) return;
    end
    imem_ack = stray; dmem_ack = stray;
    push({nm, "_wb"}, ev(3'd4, 2'd0, 0, 0, 0, 0, 1, 1, wb_sel));
    step();
    imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  // Zero-wait fetch, decode and execute of a memory instruction, stopping at MEM.
  task automatic front_mem(input logic [6:0] op, input string nm);
    opcode = op; imem_ack = 1'b1;
    push({nm, "_fetch"}, ev(3'd0, 2'd0, 1, 1, 0, 0, 0, 0, 2'd0));
    step();
    imem_ack = 1'b0;
    push({nm, "_decode"}, ev(3'd1, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0));
    step();
    push({nm, "_exec"}, ev(3'd2, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0));
    step();
  endtask

  task automatic run_illegal(input logic [6:0] op, input string nm);
    opcode = op; imem_ack = 1'b1;
    push({nm, "_fetch"}, ev(3'd0, 2'd0, 1, 1, 0, 0, 0, 0, 2'd0));
    step();
    imem_ack = 1'b0;
    push({nm, "_decode"}, ev(3'd1, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0));
    step();
    for (int unsigned i = 0; i < 20; i++) begin
      imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
      push({nm, "_trap"}, ev(3'd5, 2'd1, 0, 0, 0, 0, 0, 0, 2'd0));
      step();
    end
    do_reset(3'd5, 2'd1, {nm, "_rst"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; opcode = OP_R; funct3 = 3'd0; branch_taken = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    step();
    do_reset(3'd0, 2'd0, "reset");

    run_instr(OP_R,     1'b0, 0, 0, 1'b0, "add");
    run_instr(OP_LOAD,  1'b0, 0, 3, 1'b0, "lw");
    run_instr(OP_S,     1'b0, 1, 2, 1'b1, "sw");
    run_instr(OP_B,     1'b1, 0, 0, 1'b0, "bge_t");
    run_instr(OP_B,     1'b0, 0, 0, 1'b1, "bge_nt");
    run_instr(OP_JAL,   1'b1, 0, 0, 1'b0, "jal");
    run_instr(OP_JALR,  1'b0, 0, 0, 1'b1, "jalr");
    run_instr(OP_LUI,   1'b1, 2, 0, 1'b0, "lui");
    run_instr(OP_AUIPC, 1'b0, 0, 0, 1'b0, "auipc");
    // ack arriving on the last permitted wait cycle is still accepted
    run_instr(OP_I,     1'b0, 4, 0, 1'b0, "addi_iw4");
    run_instr(OP_LOAD,  1'b0, 0, 4, 1'b0, "lw_dw4");
    run_instr(OP_S,     1'b0, 0, 0, 1'b0, "sw_0w");

    run_illegal(7'b0000000, "ill_zero");
    run_illegal(7'b1111111, "ill_ones");
    run_instr(OP_R, 1'b0, 0, 0, 1'b0, "add_after_trap");

    // imem timeout: 5 request cycles, then TRAP with fault 2
    opcode = OP_R; imem_ack = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      push("itmo_wait", ev(3'd0, 2'd0, 1, 0, 0, 0, 0, 0, 2'd0));
      step();
    end
    for (int unsigned i = 0; i < 3; i++) begin
      push("itmo_trap", ev(3'd5, 2'd2, 0, 0, 0, 0, 0, 0, 2'd0));
      step();
    end
    do_reset(3'd5, 2'd2, "itmo_rst");

    // dmem timeout on a load: 5 MEM cycles, then TRAP with fault 3
    front_mem(OP_LOAD, "dtmo");
    for (int unsigned i = 0; i < 5; i++) begin
      push("dtmo_wait", ev(3'd3, 2'd0, 0, 0, 1, 0, 0, 0, 2'd0));
      step();
    end
    for (int unsigned i = 0; i < 2; i++) begin
      push("dtmo_trap", ev(3'd5, 2'd3, 0, 0, 0, 0, 0, 0, 2'd0));
      step();
    end
    do_reset(3'd5, 2'd3, "dtmo_rst");

    // reset while a store is waiting in MEM drops the request at once
    front_mem(OP_S, "rmem");
    for (int unsigned i = 0; i < 2; i++) begin
      push("rmem_wait", ev(3'd3, 2'd0, 0, 0, 1, 1, 0, 0, 2'd0));
      step();
    end
    do_reset(3'd3, 2'd0, "rmem_rst");
    run_instr(OP_R, 1'b0, 0, 0, 1'b0, "add_after_rst");

`ifdef CTRL_PERF_CNT_EN
    do_reset(3'd0, 2'd0, "perf_rst");
    for (int unsigned i = 0; i < 10; i++) run_instr(OP_R, 1'b0, 0, 0, 1'b0, "perf_add");
    check_eq("retired_cnt", retired_cnt, 32'd10);
    check_eq("cycle_cnt", cycle_cnt, 32'd40);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
